// File: rtl/data_mem_ws_if.sv
// LSU <-> data memory request/response bundle.
// Requests are held by the master until the one-cycle ready_o pulse.
interface data_mem_ws_if;
  logic        mem_req_i;
  logic        write_enable_i;
  logic [3:0]  byte_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        ready_o;
  logic        error_o;

  modport master (
    output mem_req_i,
    output write_enable_i,
    output byte_enable_i,
    output addr_i,
    output write_data_i,
    input  read_data_o,
    input  ready_o,
    input  error_o
  );

  modport slave (
    input  mem_req_i,
    input  write_enable_i,
    input  byte_enable_i,
    input  addr_i,
    input  write_data_i,
    output read_data_o,
    output ready_o,
    output error_o
  );
endinterface

// File: rtl/data_mem_ws.sv
// Word-organised data memory with programmable wait states,
// byte write enables and an out-of-range error response.
module data_mem_ws #(
  parameter int SIZE_BYTES = 2048,
  parameter int LATENCY    = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  data_mem_ws_if.slave bus
);
  localparam int WORDS = SIZE_BYTES / 4;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $fatal(1, "data_mem_ws: LATENCY must be 1..16");
  end
  if (SIZE_BYTES < 4 || (SIZE_BYTES & (SIZE_BYTES - 1)) != 0)
  begin : g_bad_size
    $fatal(1, "data_mem_ws: SIZE_BYTES must be a power of two >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;

  logic [31:0] mem_q [WORDS];

  logic          idle;
  logic [31:0]   acc_addr;
  logic          acc_we;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wdata;
  logic [WW-1:0] acc_idx;
  logic          acc_oor;
  logic          do_acc;
  logic          mem_we;

  // With LATENCY=1 the access happens on the acceptance edge itself,
  // so the live bus values stand in for the not-yet-captured ones.
  always_comb begin
    idle      = (state_q == S_IDLE);
    acc_addr  = idle ? bus.addr_i         : addr_q;
    acc_we    = idle ? bus.write_enable_i : we_q;
    acc_be    = idle ? bus.byte_enable_i  : be_q;
    acc_wdata = idle ? bus.write_data_i   : wdata_q;
    acc_idx   = WW'(acc_addr >> 2);
    acc_oor   = (acc_addr >= 32'(SIZE_BYTES));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    do_acc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_req_i) begin
          addr_d  = bus.addr_i;
          we_d    = bus.write_enable_i;
          be_d    = bus.byte_enable_i;
          wdata_d = bus.write_data_i;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            do_acc  = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          do_acc  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (do_acc) begin
      ready_d = 1'b1;
      error_d = acc_oor;
      if (!acc_we) begin
        rdata_d = acc_oor ? 32'h0 : mem_q[acc_idx];
      end
    end
  end

  assign mem_we = do_acc & acc_we & ~acc_oor & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.read_data_o = rdata_q;
  assign bus.ready_o     = ready_q;
  assign bus.error_o     = error_q;
endmodule

// File: tb/tb_data_mem_ws.sv
// Directed bench: four instances (LATENCY 3, 4, 1, 16) sharing clk/rst.
// Index 0:L3  1:L4  2:L1  3:L16, all SIZE_BYTES=2048.
module tb_data_mem_ws;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req   [4];
  logic        we    [4];
  logic [3:0]  be    [4];
  logic [31:0] addr  [4];
  logic [31:0] wd    [4];
  logic [31:0] rdata [4];
  logic        rdy   [4];
  logic        err   [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 1 : 16;
    data_mem_ws_if b ();
    assign b.mem_req_i      = req[g];
    assign b.write_enable_i = we[g];
    assign b.byte_enable_i  = be[g];
    assign b.addr_i         = addr[g];
    assign b.write_data_i   = wd[g];
    assign rdata[g]         = b.read_data_o;
    assign rdy[g]           = b.ready_o;
    assign err[g]           = b.error_o;
    data_mem_ws #(.SIZE_BYTES(2048), .LATENCY(L)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one access, wait (bounded) for ready, return data/error.
  task automatic access(input int d, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] v,
                        input int exp_lat, input bit tog,
                        output logic [31:0] rd, output logic er);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    req[d] = 1'b1; we[d] = w; be[d] = m; addr[d] = a; wd[d] = v;
    @(posedge clk);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[d]) got = 1;
      else if (tog) begin
        we[d] = ~we[d];
        be[d] = ~be[d];
        addr[d] = 32'h44 + 32'(n * 4);
        wd[d] = $urandom;
      end
    end
    req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
    rd = rdata[d];
    er = err[d];
    check($sformatf("latency d%0d a%h", d, a), got ? 32'(n) : 32'hFFFF,
          32'(exp_lat));
    @(negedge clk);
    check($sformatf("pulse d%0d a%h", d, a), {31'b0, rdy[d]}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    for (int i = 0; i < 4; i++) begin
      req[i] = 0; we[i] = 0; be[i] = 0; addr[i] = 0; wd[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst ready d%0d", i), {31'b0, rdy[i]}, 32'h0);
      check($sformatf("rst error d%0d", i), {31'b0, err[i]}, 32'h0);
      check($sformatf("rst rdata d%0d", i), rdata[i], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Case 1
    access(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 3, 0, rd, er);
    check("c1 wr err", {31'b0, er}, 32'h0);
    access(0, 0, 4'hF, 32'h10, 32'h0, 3, 0, rd, er);
    check("c1 rd data", rd, 32'hDEADBEEF);
    check("c1 rd err", {31'b0, er}, 32'h0);

    // Case 2
    access(0, 1, 4'b0001, 32'h10, 32'h000000AA, 3, 0, rd, er);
    access(0, 1, 4'b0100, 32'h10, 32'h00550000, 3, 0, rd, er);
    access(0, 0, 4'hF, 32'h10, 32'h0, 3, 0, rd, er);
    check("c2 rd data", rd, 32'hDE55BEAA);
    access(0, 1, 4'b0000, 32'h10, 32'hFFFFFFFF, 3, 0, rd, er);
    access(0, 0, 4'hF, 32'h10, 32'h0, 3, 0, rd, er);
    check("c2 be0 data", rd, 32'hDE55BEAA);

    // Case 3
    access(0, 1, 4'hF, 32'h0, 32'h0BADF00D, 3, 0, rd, er);
    access(0, 1, 4'hF, 32'h800, 32'h12345678, 3, 0, rd, er);
    check("c3 oor wr err", {31'b0, er}, 32'h1);
    access(0, 0, 4'hF, 32'h800, 32'h0, 3, 0, rd, er);
    check("c3 oor rd err", {31'b0, er}, 32'h1);
    check("c3 oor rd data", rd, 32'h0);
    access(0, 0, 4'hF, 32'h0, 32'h0, 3, 0, rd, er);
    check("c3 alias data", rd, 32'h0BADF00D);
    check("c3 alias err", {31'b0, er}, 32'h0);
    access(0, 0, 4'hF, 32'h7FC, 32'h0, 3, 0, rd, er);
    check("c3 top err", {31'b0, er}, 32'h0);

    // Case 4
    access(1, 1, 4'hF, 32'h20, 32'h11111111, 4, 0, rd, er);
    access(1, 0, 4'hF, 32'h20, 32'h0, 4, 0, rd, er);
    check("c4 pre data", rd, 32'h11111111);
    req[1] = 1; we[1] = 1; be[1] = 4'hF; addr[1] = 32'h20;
    wd[1] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req[1] = 0; we[1] = 0; be[1] = 0;
    #1;
    check("c4 rst ready", {31'b0, rdy[1]}, 32'h0);
    check("c4 rst error", {31'b0, err[1]}, 32'h0);
    check("c4 rst rdata", rdata[1], 32'h0);
    check("c4 rst rdata d0", rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("c4 no ready", {31'b0, rdy[1]}, 32'h0);
    end
    access(1, 0, 4'hF, 32'h20, 32'h0, 4, 0, rd, er);
    check("c4 kept data", rd, 32'h11111111);

    // Case 5
    access(2, 1, 4'hF, 32'h100, 32'hA1A1A1A1, 1, 0, rd, er);
    access(2, 1, 4'hF, 32'h104, 32'hB2B2B2B2, 1, 0, rd, er);
    access(2, 1, 4'hF, 32'h108, 32'hC3C3C3C3, 1, 0, rd, er);
    req[2] = 1; we[2] = 0; be[2] = 4'hF; addr[2] = 32'h100;
    @(posedge clk);
    @(negedge clk);
    check("c5 rdy0", {31'b0, rdy[2]}, 32'h1);
    check("c5 data0", rdata[2], 32'hA1A1A1A1);
    addr[2] = 32'h104;
    @(negedge clk);
    check("c5 gap0", {31'b0, rdy[2]}, 32'h0);
    @(negedge clk);
    check("c5 rdy1", {31'b0, rdy[2]}, 32'h1);
    check("c5 data1", rdata[2], 32'hB2B2B2B2);
    addr[2] = 32'h108;
    @(negedge clk);
    check("c5 gap1", {31'b0, rdy[2]}, 32'h0);
    @(negedge clk);
    check("c5 rdy2", {31'b0, rdy[2]}, 32'h1);
    check("c5 data2", rdata[2], 32'hC3C3C3C3);
    req[2] = 0;
    @(negedge clk);
    @(negedge clk);
    check("c5 idle", {31'b0, rdy[2]}, 32'h0);

    // Case 6
    access(3, 1, 4'hF, 32'h40, 32'h5A5AA5A5, 16, 0, rd, er);
    access(3, 1, 4'hF, 32'h44, 32'h77777777, 16, 0, rd, er);
    access(3, 0, 4'hF, 32'h40, 32'h0, 16, 1, rd, er);
    check("c6 data", rd, 32'h5A5AA5A5);
    check("c6 err", {31'b0, er}, 32'h0);
    access(3, 0, 4'hF, 32'h44, 32'h0, 16, 0, rd, er);
    check("c6 untouched", rd, 32'h77777777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ws.md
Name: data_mem_ws

Overview:
- Parametrised word-organised data memory with a programmable wait-state response, replacing the fixed-size, single-cycle data memory.
- Sits between the core's load/store unit (LSU) and the data bus.
- Capacity is set by parameter. Every access completes after LATENCY cycles with a ready_o pulse.
- Adds per-byte write enables and an out-of-range error flag.

Parameters:
- SIZE_BYTES, 2048: memory capacity in bytes. Power of two, >= 4. Word count is SIZE_BYTES/4.
- LATENCY, 1: cycles from request acceptance to ready_o. Legal range 1..16. Elaboration fails outside this range.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- mem_req_i  input  1  access request. Held by requester until ready_o.
- write_enable_i  input  1  1 = write, 0 = read.
- byte_enable_i  input  4  per-byte write mask. Bit n selects write_data_i[8n+7:8n].
- addr_i  input  32  byte address. Bits [1:0] ignored.
- write_data_i  input  32  write data.
- read_data_o  output  32  read word. Valid while ready_o = 1, held until next response.
- ready_o  output  1  one-cycle response pulse, for reads and writes.
- error_o  output  1  asserted together with ready_o when the access was out of range.

Behaviour:
- Reset (async, rst_i = 1):
  - state = IDLE, wait counter = 0.
  - ready_o = 0, error_o = 0, read_data_o = 0.
  - Captured request registers = 0.
  - Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with mem_req_i = 1, capture addr_i, write_enable_i, byte_enable_i and write_data_i.
  - If LATENCY = 1, go to RESP. Otherwise load counter = LATENCY-2 and go to WAIT.
  - With mem_req_i = 0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When counter = 0, go to RESP on the next edge.
  - Input changes during WAIT are ignored; only captured values are used.
- Access is performed on the edge that enters RESP:
  - Write: bytes with byte_enable = 1 are updated; others are unchanged. byte_enable = 0000 writes nothing but still responds.
  - Read: read_data_o <= mem[word index].
  - Write: read_data_o is unchanged.
- RESP:
  - ready_o = 1 for exactly one cycle. Return to IDLE on the next edge.
  - mem_req_i is not sampled in RESP.
  - A request still high in the first IDLE cycle is treated as a new request.
- Timing: ready_o is high exactly LATENCY cycles after the acceptance edge. Throughput is one access per LATENCY+1 cycles.
- Address decoding:
  - word index = addr_i[$clog2(SIZE_BYTES)-1:2].
  - Out of range is addr_i >= SIZE_BYTES. The access then completes normally in time, with these differences: error_o = 1 with ready_o, writes are suppressed, read_data_o = 0.
  - No wrap-around aliasing.
- ready_o, error_o and read_data_o are registered outputs, with no combinational path from inputs.
- Counter width is $clog2(LATENCY) (minimum 1).
- Reset during WAIT or RESP:
  - Pending access is abandoned, and a pending write is never committed.
  - The FSM restarts in IDLE after reset release.
  - No ready_o is produced for the abandoned request.

Test Plan:
1. LATENCY=3, write 0xDEADBEEF to 0x10 with be=1111, then read 0x10.
   - ready_o pulses 3 cycles after each acceptance.
   - read_data_o = 0xDEADBEEF, error_o = 0.
2. After case 1, write 0x000000AA to 0x10 with be=0001 and 0x00550000 with be=0100, then read.
   - read_data_o = 0xDE55BEAA.
3. SIZE_BYTES=2048: write 0x12345678 to 0x800, then read 0x800 and 0x000.
   - Both 0x800 accesses give error_o = 1 with ready_o, and the read returns 0.
   - The read of 0x000 returns its previous contents, proving no aliasing.
4. LATENCY=4: write 0xCAFEF00D to 0x20, assert rst_i during WAIT, release, then read 0x20.
   - No ready_o for the aborted write.
   - Word at 0x20 keeps its old value.
   - After reset, all outputs are 0.
5. LATENCY=1 with mem_req_i held high for 3 consecutive accesses.
   - ready_o pulses on alternate cycles: accept, RESP, accept...
   - Each pulse returns the data for the matching address.
6. LATENCY=16 read.
   - ready_o is asserted exactly 16 cycles after acceptance.
   - Inputs toggled during WAIT do not alter the result.
